pdt_tournament: RTL and testbench

Parametrised successor to the single-table branch predictor. It provides a bimodal/gshare tournament predictor with a direct-mapped BTB, so taken-branch targets are known in IF. Lookup is combinational from the fetch PC, and results are carried down the pipeline as opaque metadata. ID resolves each branch and returns an update that trains the tables and repairs the speculative global history on a mispredict.

---
 rtl/pdt_pkg.sv | 35 +++
 rtl/pdt_if.sv | 47 ++++
 rtl/pdt_ctr_table.sv | 43 ++++
 rtl/pdt_tournament.sv | 185 ++++++++++++++++++
 tb/tb_pdt_tournament.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/pdt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pdt_pkg
// Description : Shared definitions for the tournament branch predictor.
//               Holds the 2-bit counter encodings, saturating step helpers
//               and the bit offsets of the fields inside the prediction
//               metadata word {ghr_snap, bim_pred, gsh_pred, use_gsh}.
// Revision    : 1.0 - initial release
// ============================================================================
package pdt_pkg;

  typedef logic [1:0] ctr_t;

  // Saturating counter encodings; prediction is the MSB.
  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // Field positions inside the metadata word.
  localparam int GHR_LSB = 3;
  localparam int BIM_BIT = 2;
  localparam int GSH_BIT = 1;
  localparam int SEL_BIT = 0;

  function automatic ctr_t sat_inc(input ctr_t ctr);
    return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
  endfunction

  function automatic ctr_t sat_dec(input ctr_t ctr);
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pdt_if.sv
`default_nettype none
// ============================================================================
// Module      : pdt_if
// Description : Pipeline <-> predictor bundle.
//               Lookup : if_pc, if_stall -> pdt_taken, pdt_target, pdt_meta
//               Update : upd_valid, upd_pc, upd_taken, upd_target,
//                        upd_mispredict, upd_meta
//               Stats  : stat_branches, stat_mispredicts
//               master = pipeline side, slave = predictor side.
// Revision    : 1.0 - initial release
// ============================================================================
interface pdt_if #(
  parameter int ADDR_W = 32,
  parameter int HIST_W = 10
);
  localparam int META_W = HIST_W + 3;

  logic              if_stall;
  logic [ADDR_W-1:0] if_pc;
  logic              pdt_taken;
  logic [ADDR_W-1:0] pdt_target;
  logic [META_W-1:0] pdt_meta;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_mispredict;
  logic [META_W-1:0] upd_meta;
  logic [31:0]       stat_branches;
  logic [31:0]       stat_mispredicts;

  modport master (
    output if_pc, if_stall,
    output upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, upd_meta,
    input  pdt_taken, pdt_target, pdt_meta,
    input  stat_branches, stat_mispredicts
  );

  modport slave (
    input  if_pc, if_stall,
    input  upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, upd_meta,
    output pdt_taken, pdt_target, pdt_meta,
    output stat_branches, stat_mispredicts
  );

endinterface
`default_nettype wire

// File: rtl/pdt_ctr_table.sv
`default_nettype none
// ============================================================================
// Module      : pdt_ctr_table
// Description : Array of 2^IDX_W 2-bit saturating counters.
//               One combinational read port, one inc/dec write port.
//               clk, rst (async, active-low)
//               rd_idx -> rd_ctr    : read, old value during same-cycle write
//               wr_en, wr_idx, wr_inc : step entry toward taken (wr_inc=1)
//                                       or not-taken (wr_inc=0)
// Revision    : 1.0 - initial release
// ============================================================================
module pdt_ctr_table
  import pdt_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output ctr_t             rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_inc
);

  localparam int DEPTH = 2 ** IDX_W;

  ctr_t r_ctr [DEPTH];

  assign rd_ctr = r_ctr[rd_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ctr[i] <= CTR_WNT;
      end
    end else if (wr_en) begin
      r_ctr[wr_idx] <= wr_inc ? sat_inc(r_ctr[wr_idx]) : sat_dec(r_ctr[wr_idx]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pdt_tournament.sv
`default_nettype none
// ============================================================================
// Module      : pdt_tournament
// Description : Bimodal/gshare tournament branch predictor with a
//               direct-mapped BTB. Lookup is combinational from if_pc;
//               resolved branches train the tables and repair the
//               speculative global history on a mispredict.
//               clk  : clock
//               rst  : asynchronous, active-low reset
//               bus  : pdt_if.slave (lookup, update and statistics)
// Revision    : 1.0 - initial release
// ============================================================================
module pdt_tournament
  import pdt_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int HIST_W    = 10,
  parameter int BIM_IDX_W = 10,
  parameter int BTB_IDX_W = 6
) (
  input  logic  clk,
  input  logic  rst,
  pdt_if.slave  bus
);

  localparam int META_W = HIST_W + 3;
  localparam int TAG_W  = ADDR_W - BTB_IDX_W - 2;
  localparam int BTB_N  = 2 ** BTB_IDX_W;
  localparam logic [ADDR_W-1:0] c_pc_step = ADDR_W'(4);

  // History shift needs at least two bits to have a body and an LSB.
  if (HIST_W < 2) begin : g_hist_w_check
    $error("pdt_tournament: HIST_W must be >= 2");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [HIST_W-1:0] r_ghr;
  logic [BTB_N-1:0]  r_btb_valid;
  logic [TAG_W-1:0]  r_btb_tag    [BTB_N];
  logic [ADDR_W-1:0] r_btb_target [BTB_N];
  logic [31:0]       r_stat_br;
  logic [31:0]       r_stat_mis;

  // --------------------------------------------------------------------------
  // Lookup
  // --------------------------------------------------------------------------
  ctr_t                 w_bim_ctr;
  ctr_t                 w_gsh_ctr;
  ctr_t                 w_sel_ctr;
  logic [HIST_W-1:0]    w_gsh_rd_idx;
  logic [BTB_IDX_W-1:0] w_btb_rd_idx;
  logic                 w_hit;
  logic                 w_use_gsh;
  logic                 w_pred_taken;

  assign w_gsh_rd_idx = bus.if_pc[HIST_W+1:2] ^ r_ghr;
  assign w_btb_rd_idx = bus.if_pc[BTB_IDX_W+1:2];
  assign w_hit        = r_btb_valid[w_btb_rd_idx] &&
                        (r_btb_tag[w_btb_rd_idx] == bus.if_pc[ADDR_W-1:BTB_IDX_W+2]);
  assign w_use_gsh    = w_sel_ctr[1];
  // Without a BTB hit there is no target to redirect to, so never predict taken.
  assign w_pred_taken = w_hit && (w_use_gsh ? w_gsh_ctr[1] : w_bim_ctr[1]);

  assign bus.pdt_taken  = w_pred_taken;
  assign bus.pdt_target = w_pred_taken ? r_btb_target[w_btb_rd_idx] : bus.if_pc + c_pc_step;
  assign bus.pdt_meta   = {r_ghr, w_bim_ctr[1], w_gsh_ctr[1], w_use_gsh};

  // --------------------------------------------------------------------------
  // Update side decode
  // --------------------------------------------------------------------------
  logic [HIST_W-1:0]    w_upd_snap;
  logic [HIST_W-1:0]    w_gsh_wr_idx;
  logic                 w_upd_bim_pred;
  logic                 w_upd_gsh_pred;
  logic                 w_sel_wr_en;
  logic                 w_sel_wr_inc;
  logic [BTB_IDX_W-1:0] w_btb_wr_idx;
  logic                 w_btb_wr;
  logic                 w_repair;

  assign w_upd_snap     = bus.upd_meta[GHR_LSB +: HIST_W];
  assign w_upd_bim_pred = bus.upd_meta[BIM_BIT];
  assign w_upd_gsh_pred = bus.upd_meta[GSH_BIT];
  // Gshare trains the entry that produced the prediction, i.e. with the
  // history as it was at lookup time.
  assign w_gsh_wr_idx   = bus.upd_pc[HIST_W+1:2] ^ w_upd_snap;
  // Chooser only learns when the components disagreed.
  assign w_sel_wr_en    = bus.upd_valid && (w_upd_bim_pred != w_upd_gsh_pred);
  assign w_sel_wr_inc   = (w_upd_gsh_pred == bus.upd_taken);
  assign w_btb_wr_idx   = bus.upd_pc[BTB_IDX_W+1:2];
  assign w_btb_wr       = bus.upd_valid && bus.upd_taken;
  assign w_repair       = bus.upd_valid && bus.upd_mispredict;

  logic w_unused;
  assign w_unused = ^{bus.upd_pc[1:0], bus.upd_meta[SEL_BIT]};

  // --------------------------------------------------------------------------
  // Counter tables
  // --------------------------------------------------------------------------
  pdt_ctr_table #(.IDX_W(BIM_IDX_W)) u_bim (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (bus.if_pc[BIM_IDX_W+1:2]),
    .rd_ctr (w_bim_ctr),
    .wr_en  (bus.upd_valid),
    .wr_idx (bus.upd_pc[BIM_IDX_W+1:2]),
    .wr_inc (bus.upd_taken)
  );

  pdt_ctr_table #(.IDX_W(HIST_W)) u_gsh (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (w_gsh_rd_idx),
    .rd_ctr (w_gsh_ctr),
    .wr_en  (bus.upd_valid),
    .wr_idx (w_gsh_wr_idx),
    .wr_inc (bus.upd_taken)
  );

  pdt_ctr_table #(.IDX_W(HIST_W)) u_sel (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (bus.if_pc[HIST_W+1:2]),
    .rd_ctr (w_sel_ctr),
    .wr_en  (w_sel_wr_en),
    .wr_idx (bus.upd_pc[HIST_W+1:2]),
    .wr_inc (w_sel_wr_inc)
  );

  // --------------------------------------------------------------------------
  // Global history: repair from the branch's own snapshot wins over the
  // speculative shift of whatever is being fetched this cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ghr <= '0;
    end else if (w_repair) begin
      r_ghr <= {w_upd_snap[HIST_W-2:0], bus.upd_taken};
    end else if (w_hit && !bus.if_stall) begin
      r_ghr <= {r_ghr[HIST_W-2:0], w_pred_taken};
    end
  end

  // --------------------------------------------------------------------------
  // BTB: only valid bits need reset; tag/target are qualified by valid.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btb_valid <= '0;
    end else if (w_btb_wr) begin
      r_btb_valid[w_btb_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_btb_wr) begin
      r_btb_tag[w_btb_wr_idx]    <= bus.upd_pc[ADDR_W-1:BTB_IDX_W+2];
      r_btb_target[w_btb_wr_idx] <= bus.upd_target;
    end
  end

  // --------------------------------------------------------------------------
  // Statistics (saturating)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_br  <= '0;
      r_stat_mis <= '0;
    end else if (bus.upd_valid) begin
      if (r_stat_br != '1) begin
        r_stat_br <= r_stat_br + 32'd1;
      end
      if (bus.upd_mispredict && (r_stat_mis != '1)) begin
        r_stat_mis <= r_stat_mis + 32'd1;
      end
    end
  end

  assign bus.stat_branches    = r_stat_br;
  assign bus.stat_mispredicts = r_stat_mis;

endmodule
`default_nettype wire

// File: tb/tb_pdt_tournament.sv
`default_nettype none
// ============================================================================
// Module      : tb_pdt_tournament
// Description : Directed self-checking bench for pdt_tournament. Expected
//               lookup results are queued when a lookup is driven and
//               popped when the combinational outputs have settled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pdt_tournament;
  import pdt_pkg::*;

  localparam int ADDR_W = 32;
  localparam int HIST_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pdt_if #(.ADDR_W(ADDR_W), .HIST_W(HIST_W)) bus ();

  pdt_tournament #(
    .ADDR_W    (ADDR_W),
    .HIST_W    (HIST_W),
    .BIM_IDX_W (10),
    .BTB_IDX_W (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic        taken;
    logic [31:0] target;
    logic [9:0]  ghr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [12:0] mk_meta(input logic [9:0] snap, input logic b,
                                          input logic g, input logic s);
    return {snap, b, g, s};
  endfunction

  task automatic push_exp(input string tag, input logic t, input logic [31:0] tg,
                          input logic [9:0] g);
    exp_t e;
    e.tag = tag; e.taken = t; e.target = tg; e.ghr = g;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, "_taken"},  32'(bus.pdt_taken), 32'(e.taken));
    chk({e.tag, "_target"}, bus.pdt_target, e.target);
    chk({e.tag, "_ghr"},    32'(bus.pdt_meta[GHR_LSB +: HIST_W]), 32'(e.ghr));
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic t, input logic [31:0] tg,
                           input logic mis, input logic [12:0] meta);
    bus.upd_valid      = 1'b1;
    bus.upd_pc         = pc;
    bus.upd_taken      = t;
    bus.upd_target     = tg;
    bus.upd_mispredict = mis;
    bus.upd_meta       = meta;
  endtask

  // Called at a negedge: drive lookup, check before the edge, let the edge
  // commit any pending update, return at the following negedge.
  task automatic look(input string tag, input logic [31:0] pc, input logic stall,
                      input logic t, input logic [31:0] tg, input logic [9:0] g);
    bus.if_pc    = pc;
    bus.if_stall = stall;
    push_exp(tag, t, tg, g);
    #1;
    pop_check();
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        dir;
    logic        pred;
    logic        mis;
    logic [12:0] meta_c;
    logic [31:0] tgt_c;
    int          mis_cnt;

    bus.if_pc = '0; bus.if_stall = 1'b0;
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
    bus.upd_target = '0; bus.upd_mispredict = 1'b0; bus.upd_meta = '0;

    // ---------------- reset ----------------
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    look("reset_lookup", 32'h100, 1'b0, 1'b0, 32'h104, 10'h0);
    bus.if_pc = 32'h100;
    #1;
    chk("reset_meta", 32'(bus.pdt_meta), 32'h0);
    chk("reset_stat_br", bus.stat_branches, 32'd0);
    chk("reset_stat_mis", bus.stat_mispredicts, 32'd0);

    // ---------------- first taken update ----------------
    drive_upd(32'h100, 1'b1, 32'h200, 1'b0, mk_meta(10'h0, 1'b0, 1'b0, 1'b0));
    look("train_same_cycle", 32'h100, 1'b1, 1'b0, 32'h104, 10'h0);
    bus.if_pc = 32'h100; bus.if_stall = 1'b0;
    #1;
    chk("hit_meta", 32'(bus.pdt_meta), 32'h6);
    look("hit_after_train", 32'h100, 1'b0, 1'b1, 32'h200, 10'h0);
    look("ghr_shifted", 32'h100, 1'b1, 1'b1, 32'h200, 10'h1);
    chk("stat_br_1", bus.stat_branches, 32'd1);
    chk("stat_mis_0", bus.stat_mispredicts, 32'd0);

    // ---------------- saturation then step down ----------------
    for (int i = 0; i < 4; i++) begin
      drive_upd(32'h100, 1'b1, 32'h200, 1'b0, mk_meta(10'h0, 1'b1, 1'b1, 1'b0));
      look("sat_train", 32'h100, 1'b1, 1'b1, 32'h200, 10'h1);
    end
    drive_upd(32'h100, 1'b0, 32'h0, 1'b0, mk_meta(10'h0, 1'b1, 1'b1, 1'b0));
    look("nt1_same_cycle", 32'h100, 1'b1, 1'b1, 32'h200, 10'h1);
    look("nt1_still_taken", 32'h100, 1'b1, 1'b1, 32'h200, 10'h1);
    drive_upd(32'h100, 1'b0, 32'h0, 1'b0, mk_meta(10'h0, 1'b1, 1'b1, 1'b0));
    look("nt2_old_value", 32'h100, 1'b1, 1'b1, 32'h200, 10'h1);
    look("nt2_not_taken", 32'h100, 1'b1, 1'b0, 32'h104, 10'h1);
    chk("stat_br_7", bus.stat_branches, 32'd7);

    // ---------------- repair beats same-cycle speculative shift ----------------
    drive_upd(32'h500, 1'b0, 32'h0, 1'b1, mk_meta(10'h155, 1'b0, 1'b0, 1'b0));
    look("repair_cycle", 32'h100, 1'b0, 1'b0, 32'h104, 10'h1);
    look("repair_ghr", 32'h100, 1'b1, 1'b0, 32'h104, 10'h2AA);
    chk("stat_br_8", bus.stat_branches, 32'd8);
    chk("stat_mis_1", bus.stat_mispredicts, 32'd1);

    // ---------------- asynchronous reset during an update ----------------
    drive_upd(32'h700, 1'b1, 32'h780, 1'b1, mk_meta(10'h3FF, 1'b0, 1'b0, 1'b0));
    bus.if_pc = 32'h100; bus.if_stall = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    push_exp("rst_mid", 1'b0, 32'h104, 10'h0);
    pop_check();
    chk("rst_mid_meta", 32'(bus.pdt_meta), 32'h0);
    chk("rst_mid_stat_br", bus.stat_branches, 32'd0);
    chk("rst_mid_stat_mis", bus.stat_mispredicts, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.upd_valid = 1'b0;
    rst = 1'b1;
    look("post_rst_update_lost", 32'h700, 1'b1, 1'b0, 32'h704, 10'h0);
    look("post_rst_btb_clear", 32'h100, 1'b1, 1'b0, 32'h104, 10'h0);
    chk("post_rst_stat_br", bus.stat_branches, 32'd0);

    // ---------------- alternating branch at 0x300 ----------------
    mis_cnt = 0;
    meta_c  = '0;
    for (int i = 0; i < 40; i++) begin
      dir = (i % 2 == 0);
      bus.if_pc = 32'h300; bus.if_stall = 1'b0; bus.upd_valid = 1'b0;
      #1;
      pred   = bus.pdt_taken;
      meta_c = bus.pdt_meta;
      tgt_c  = bus.pdt_target;
      if (i >= 30) begin
        // Steady state: history alternates, gshare chosen and always right.
        push_exp("alt_steady", dir, dir ? 32'h380 : 32'h304, dir ? 10'h2AA : 10'h155);
        pop_check();
      end
      @(posedge clk);
      @(negedge clk);
      mis = (pred != dir) || (pred && (tgt_c != 32'h380));
      if (mis) mis_cnt++;
      drive_upd(32'h300, dir, 32'h380, mis, meta_c);
      bus.if_stall = 1'b1;
      @(posedge clk);
      #1;
      bus.upd_valid = 1'b0;
      @(negedge clk);
    end
    chk("alt_use_gsh", 32'(meta_c[SEL_BIT]), 32'd1);
    chk("alt_stat_br", bus.stat_branches, 32'd40);
    chk("alt_stat_mis", bus.stat_mispredicts, 32'(mis_cnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
